axi_lite_master_bridge: RTL
===========================

// Module: axi_lite_master_bridge
// PURPOSE
//  AXI-Lite initiator: turns a single-outstanding request/response port into AXI-Lite
//  write (AW/W/B) and read (AR/R) transactions toward memory-mapped slaves (UART at
//  0x0200_0004 divisor, 0x0200_0008 TX data, 0x0200_000C RX/status). Sits between a
//  simple CPU/debug port and the AXI-Lite fabric. No BRESP/RRESP/PROT, as in the fabric.
// PARAMETERS
//  ADDR_WIDTH      32    address width of request and AXI channels
//  DATA_WIDTH      32    data width; wstrb is DATA_WIDTH/8 (=4)
//  TIMEOUT_CYCLES  256   wait-state limit per channel (used only with AXI_TIMEOUT_EN)
// PORTS
//  clk            in   1           single clock, all logic on rising edge
//  reset          in   1           asynchronous, active-high reset
//  i_req_valid    in   1           request present
//  o_req_ready    out  1           bridge idle, request accepted on valid&ready
//  i_req_we       in   1           1=write, 0=read
//  i_req_addr     in   ADDR_WIDTH  target address
//  i_req_wdata    in   DATA_WIDTH  write data
//  i_req_wstrb    in   4           write byte strobes
//  o_rsp_valid    out  1           response present, held until i_rsp_ready
//  i_rsp_ready    in   1           response consumer ready
//  o_rsp_rdata    out  DATA_WIDTH  read data (0 for writes)
//  o_rsp_err      out  1           transaction timed out (constant 0 without AXI_TIMEOUT_EN)
//  o_axi_awaddr/awvalid out, i_axi_awready in     write address channel
//  o_axi_wdata/wstrb/wvalid out, i_axi_wready in  write data channel
//  i_axi_bvalid in, o_axi_bready out              write response channel
//  o_axi_araddr/arvalid out, i_axi_arready in     read address channel
//  i_axi_rdata/rvalid in, o_axi_rready out        read data channel
// BEHAVIOUR
//  - All outputs registered. Reset: state IDLE, o_req_ready=1, all valids/readies=0,
//    o_rsp_rdata=0, o_rsp_err=0, awaddr/araddr/wdata/wstrb=0. Reset mid-transaction
//    drops every valid immediately; no response is produced for the aborted request.
//  - FSM: IDLE, WR_REQ, WR_RESP, RD_ADDR, RD_DATA, RSP. One transaction outstanding.
//  - IDLE: o_req_ready=1. On i_req_valid: latch addr/wdata/wstrb; we=1 -> WR_REQ with
//    awvalid=wvalid=1 next cycle; we=0 -> RD_ADDR with arvalid=1 next cycle.
//  - WR_REQ: awvalid and wvalid each drop the cycle after own handshake, independently;
//    both done (same cycle allowed) -> WR_RESP with bready=1. Payload stable while valid.
//  - WR_RESP: on bvalid&bready -> bready=0, rdata=0, RSP.
//  - RD_ADDR: arvalid held until arready -> RD_DATA with rready=1.
//  - RD_DATA: on rvalid&rready capture i_axi_rdata into o_rsp_rdata, rready=0, RSP.
//  - RSP: o_rsp_valid=1, payload stable; on i_rsp_ready -> IDLE, o_req_ready=1 next cycle.
//  - Minimum latency, zero-wait slave: accept N, AW/W hs N+1, B hs N+2, rsp_valid N+3.
//    Read: AR hs N+1, R hs N+2, rsp_valid N+3.
//  - bready/rready never asserted outside WR_RESP/RD_DATA; an unexpected bvalid/rvalid
//    is ignored.
// CONFIGURATION
//  AXI_TIMEOUT_EN defined: per-state counter cleared on state entry; if WR_REQ, WR_RESP,
//    RD_ADDR or RD_DATA lasts TIMEOUT_CYCLES cycles without completing, drop all valids and
//    readies, go to RSP with o_rsp_err=1, o_rsp_rdata=0 (fault recovery only).
//  Undefined: no counter; waits indefinitely; o_rsp_err tied 0.
// TESTING
//  1 write 0x0200_0004 data 0x36 strb 0xF, zero-wait slave -> awaddr/wdata seen, one B,
//    rsp_valid at N+3 with rdata=0, err=0.
//  2 read 0x0200_000C, slave returns 0x0000_0141 after 2 wait cycles -> rsp_rdata=0x141.
//  3 awready immediate, wready after 5 cycles -> awvalid high 1 cycle, wvalid 5, one B only.
//  4 two back-to-back writes, i_rsp_ready low 3 cycles -> o_req_ready 0 until rsp consumed,
//    second AW not issued before first rsp handshake.
//  5 reset asserted while wvalid pending -> all valids 0 same cycle, IDLE, no rsp.
//  6 AXI_TIMEOUT_EN, TIMEOUT_CYCLES=16, slave never asserts arready -> arvalid drops after
//    16 cycles, rsp_err=1, rsp_rdata=0.

Source files
------------

// File: rtl/axi_lite_master_bridge_if.sv
// Request/response port and AXI-Lite channels of the bridge, grouped as one bundle.
// The master modport is the bridge's view. The slave modport is the view of the
// environment, which is the CPU/debug port plus the AXI-Lite fabric.
interface axi_lite_master_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // request / response port
  logic                  i_req_valid;
  logic                  o_req_ready;
  logic                  i_req_we;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic [DATA_WIDTH-1:0] i_req_wdata;
  logic [STRB_WIDTH-1:0] i_req_wstrb;
  logic                  o_rsp_valid;
  logic                  i_rsp_ready;
  logic [DATA_WIDTH-1:0] o_rsp_rdata;
  logic                  o_rsp_err;

  // AXI-Lite write channels
  logic [ADDR_WIDTH-1:0] o_axi_awaddr;
  logic                  o_axi_awvalid;
  logic                  i_axi_awready;
  logic [DATA_WIDTH-1:0] o_axi_wdata;
  logic [STRB_WIDTH-1:0] o_axi_wstrb;
  logic                  o_axi_wvalid;
  logic                  i_axi_wready;
  logic                  i_axi_bvalid;
  logic                  o_axi_bready;

  // AXI-Lite read channels
  logic [ADDR_WIDTH-1:0] o_axi_araddr;
  logic                  o_axi_arvalid;
  logic                  i_axi_arready;
  logic [DATA_WIDTH-1:0] i_axi_rdata;
  logic                  i_axi_rvalid;
  logic                  o_axi_rready;

  modport master (
    input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wstrb, i_rsp_ready,
    input  i_axi_awready, i_axi_wready, i_axi_bvalid, i_axi_arready, i_axi_rdata, i_axi_rvalid,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    output o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wstrb, o_axi_wvalid, o_axi_bready,
    output o_axi_araddr, o_axi_arvalid, o_axi_rready
  );

  modport slave (
    output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wstrb, i_rsp_ready,
    output i_axi_awready, i_axi_wready, i_axi_bvalid, i_axi_arready, i_axi_rdata, i_axi_rvalid,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err,
    input  o_axi_awaddr, o_axi_awvalid, o_axi_wdata, o_axi_wstrb, o_axi_wvalid, o_axi_bready,
    input  o_axi_araddr, o_axi_arvalid, o_axi_rready
  );
endinterface

// File: rtl/axi_lite_master_bridge.sv
// AXI-Lite initiator bridge. It turns a single-outstanding request/response port into
// AXI-Lite write (AW/W/B) and read (AR/R) transactions. Every output is registered.
// Optional feature macro AXI_TIMEOUT_EN: with it, a per-state wait counter aborts a
// stuck channel after TIMEOUT_CYCLES cycles and returns o_rsp_err=1. Without it the
// bridge waits indefinitely and o_rsp_err is tied low.
module axi_lite_master_bridge #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                     clk,
  input logic                     reset,
  axi_lite_master_bridge_if.master bus
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state, state_nxt;
  logic                  req_ready_q, req_ready_nxt;
  logic                  rsp_valid_q, rsp_valid_nxt;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_nxt;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_nxt;
  logic                  awvalid_q, awvalid_nxt;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_nxt;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_nxt;
  logic                  wvalid_q, wvalid_nxt;
  logic                  bready_q, bready_nxt;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_nxt;
  logic                  arvalid_q, arvalid_nxt;
  logic                  rready_q, rready_nxt;

`ifdef AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             rsp_err_q, rsp_err_nxt;
  logic             wait_state;

  assign wait_state = (state == WR_REQ) || (state == WR_RESP) ||
                      (state == RD_ADDR) || (state == RD_DATA);
`endif

  // Next state and next value of every registered output.
  always_comb begin
    state_nxt     = state;
    req_ready_nxt = req_ready_q;
    rsp_valid_nxt = rsp_valid_q;
    rsp_rdata_nxt = rsp_rdata_q;
    awaddr_nxt    = awaddr_q;
    awvalid_nxt   = awvalid_q;
    wdata_nxt     = wdata_q;
    wstrb_nxt     = wstrb_q;
    wvalid_nxt    = wvalid_q;
    bready_nxt    = bready_q;
    araddr_nxt    = araddr_q;
    arvalid_nxt   = arvalid_q;
    rready_nxt    = rready_q;
`ifdef AXI_TIMEOUT_EN
    rsp_err_nxt   = rsp_err_q;
`endif

    unique case (state)
      IDLE: begin
        if (bus.i_req_valid && req_ready_q) begin
          req_ready_nxt = 1'b0;
          if (bus.i_req_we) begin
            awaddr_nxt  = bus.i_req_addr;
            wdata_nxt   = bus.i_req_wdata;
            wstrb_nxt   = bus.i_req_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_REQ;
          end else begin
            araddr_nxt  = bus.i_req_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = RD_ADDR;
          end
        end
      end

      // AW and W complete independently; B is awaited once both are done.
      WR_REQ: begin
        if (awvalid_q && bus.i_axi_awready) awvalid_nxt = 1'b0;
        if (wvalid_q && bus.i_axi_wready)   wvalid_nxt  = 1'b0;
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (bus.i_axi_bvalid && bready_q) begin
          bready_nxt    = 1'b0;
          rsp_rdata_nxt = '0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
      end

      RD_ADDR: begin
        if (arvalid_q && bus.i_axi_arready) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (bus.i_axi_rvalid && rready_q) begin
          rsp_rdata_nxt = bus.i_axi_rdata;
          rready_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
      end

      RSP: begin
        if (bus.i_rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
          state_nxt     = IDLE;
        end
      end

      default: begin
        state_nxt     = IDLE;
        req_ready_nxt = 1'b1;
        rsp_valid_nxt = 1'b0;
        awvalid_nxt   = 1'b0;
        wvalid_nxt    = 1'b0;
        bready_nxt    = 1'b0;
        arvalid_nxt   = 1'b0;
        rready_nxt    = 1'b0;
      end
    endcase

`ifdef AXI_TIMEOUT_EN
    // A fresh request clears the error flag. A wait state that has stalled for the
    // full limit, and does not complete this cycle, is abandoned with an error response.
    if (state == IDLE && bus.i_req_valid && req_ready_q) rsp_err_nxt = 1'b0;
    if (wait_state && (state_nxt == state) &&
        (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      bready_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rready_nxt    = 1'b0;
      rsp_rdata_nxt = '0;
      rsp_err_nxt   = 1'b1;
      rsp_valid_nxt = 1'b1;
      state_nxt     = RSP;
    end
`endif
  end

  // State register and registered outputs; reset drops every valid and ready at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      awaddr_q    <= '0;
      awvalid_q   <= 1'b0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      araddr_q    <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_ready_q <= req_ready_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_rdata_q <= rsp_rdata_nxt;
      awaddr_q    <= awaddr_nxt;
      awvalid_q   <= awvalid_nxt;
      wdata_q     <= wdata_nxt;
      wstrb_q     <= wstrb_nxt;
      wvalid_q    <= wvalid_nxt;
      bready_q    <= bready_nxt;
      araddr_q    <= araddr_nxt;
      arvalid_q   <= arvalid_nxt;
      rready_q    <= rready_nxt;
    end
  end

`ifdef AXI_TIMEOUT_EN
  // Cycles spent in the current wait state; restarts on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_cnt   <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      rsp_err_q <= rsp_err_nxt;
      if (state_nxt != state || !wait_state) tmo_cnt <= '0;
      else                                   tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end

  assign bus.o_rsp_err = rsp_err_q;
`else
  // The timeout limit only matters when the watchdog is built in.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign bus.o_rsp_err      = 1'b0;
`endif

  assign bus.o_req_ready   = req_ready_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_axi_awaddr  = awaddr_q;
  assign bus.o_axi_awvalid = awvalid_q;
  assign bus.o_axi_wdata   = wdata_q;
  assign bus.o_axi_wstrb   = wstrb_q;
  assign bus.o_axi_wvalid  = wvalid_q;
  assign bus.o_axi_bready  = bready_q;
  assign bus.o_axi_araddr  = araddr_q;
  assign bus.o_axi_arvalid = arvalid_q;
  assign bus.o_axi_rready  = rready_q;
endmodule
